// File: rtl/uart_bus_bridge.sv
// uart_bus_bridge: bus initiator driven by UART command frames (0x57 write / 0x52 read),
// answering with ACK, read data or NAK, and aborting bus requests after TIMEOUT_CYCLES.
module uart_bus_bridge #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk_in,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_data_valid,
    output logic        rx_data_ready,
    output logic [7:0]  tx_data,
    output logic        tx_data_valid,
    input  logic        tx_data_ready,
    output logic        write_valid,
    input  logic        write_ready,
    output logic [31:0] write_address,
    output logic [31:0] write_data,
    output logic        read_ready,
    input  logic        read_valid,
    output logic [31:0] read_address,
    input  logic [31:0] read_data
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    typedef enum logic [2:0] {IDLE, ADDR, DATA, BUS_WR, BUS_RD, RESP} state_t;
    state_t state;
    logic [1:0] cnt;
    logic is_wr;
    logic [31:0] addr, data, rbuf;
    logic [TW-1:0] tmo;
    logic rx_fire, tx_fire, tmo_hit;
    assign rx_data_ready = state inside {IDLE, ADDR, DATA};
    assign rx_fire = rx_data_valid && rx_data_ready;
    assign tx_fire = tx_data_valid && tx_data_ready;
    assign tmo_hit = tmo == TW'(TIMEOUT_CYCLES - 1);
    assign write_address = addr;
    assign read_address = addr;
    assign write_data = data;
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt <= '0;
            is_wr <= 1'b0;
            addr <= '0;
            data <= '0;
            rbuf <= '0;
            tmo <= '0;
            tx_data <= '0;
            tx_data_valid <= 1'b0;
            write_valid <= 1'b0;
            read_ready <= 1'b0;
        end else begin
            case (state)
                IDLE: if (rx_fire) begin
                    cnt <= '0;
                    is_wr <= rx_data == 8'h57;
                    if (rx_data == 8'h57 || rx_data == 8'h52) begin
                        state <= ADDR;
                    end else begin
                        state <= RESP;
                        tx_data <= 8'h15;
                        tx_data_valid <= 1'b1;
                    end
                end
                ADDR: if (rx_fire) begin
                    addr <= {addr[23:0], rx_data};
                    cnt <= cnt + 1'b1;
                    if (cnt == 2'd3) begin
                        tmo <= '0;
                        state <= is_wr ? DATA : BUS_RD;
                        read_ready <= !is_wr;
                    end
                end
                DATA: if (rx_fire) begin
                    data <= {data[23:0], rx_data};
                    cnt <= cnt + 1'b1;
                    if (cnt == 2'd3) begin
                        tmo <= '0;
                        state <= BUS_WR;
                        write_valid <= 1'b1;
                    end
                end
                // Completion wins over timeout when both land in the same cycle
                BUS_WR: if (write_ready || tmo_hit) begin
                    write_valid <= 1'b0;
                    state <= RESP;
                    cnt <= '0;
                    tx_data <= write_ready ? 8'h06 : 8'h15;
                    tx_data_valid <= 1'b1;
                end else begin
                    tmo <= tmo + 1'b1;
                end
                BUS_RD: if (read_valid || tmo_hit) begin
                    read_ready <= 1'b0;
                    state <= RESP;
                    cnt <= read_valid ? 2'd3 : 2'd0;
                    tx_data <= read_valid ? read_data[31:24] : 8'h15;
                    tx_data_valid <= 1'b1;
                    if (read_valid) rbuf <= {read_data[23:0], 8'h00};
                end else begin
                    tmo <= tmo + 1'b1;
                end
                // cnt holds the number of response bytes still queued behind tx_data
                RESP: if (tx_fire) begin
                    if (cnt == 2'd0) begin
                        state <= IDLE;
                        tx_data_valid <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                        tx_data <= rbuf[31:24];
                        rbuf <= {rbuf[23:0], 8'h00};
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_bus_bridge.sv
// tb_uart_bus_bridge: randomized frames against a response/bus model of the UART bus bridge.
module tb_uart_bus_bridge;
    localparam int TMO = 1024;
    logic clk_in = 1'b0;
    logic rst_n = 1'b0;
    logic [7:0] rx_data = '0;
    logic rx_data_valid = 1'b0;
    logic rx_data_ready;
    logic [7:0] tx_data;
    logic tx_data_valid;
    logic tx_data_ready = 1'b1;
    logic write_valid;
    logic write_ready = 1'b0;
    logic [31:0] write_address, write_data;
    logic read_ready;
    logic read_valid = 1'b0;
    logic [31:0] read_address;
    logic [31:0] read_data = '0;

    uart_bus_bridge #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk_in(clk_in), .rst_n(rst_n),
        .rx_data(rx_data), .rx_data_valid(rx_data_valid), .rx_data_ready(rx_data_ready),
        .tx_data(tx_data), .tx_data_valid(tx_data_valid), .tx_data_ready(tx_data_ready),
        .write_valid(write_valid), .write_ready(write_ready),
        .write_address(write_address), .write_data(write_data),
        .read_ready(read_ready), .read_valid(read_valid),
        .read_address(read_address), .read_data(read_data)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0, fails = 0, cyc = 0;
    int wr_lat = 0, rd_lat = 0, tx_mode = 0;
    logic [31:0] rd_val = '0;
    int wk = 0, rk = 0, tk = 0;
    logic [7:0] tx_q[$];
    int tx_t[$];
    logic [31:0] wa_q[$], wd_q[$], ra_q[$];
    int wv_len[$];
    int wv_run = 0, last_acc = 0, req_start = 0, bus_reqs = 0;
    logic prev_req = 0, prev_wv = 0, prev_rr = 0, hold_p = 0;
    logic [31:0] pa = '0, pd = '0, pra = '0;
    logic [7:0] hold_b = '0;
    logic [7:0] exp_q[$];

    // Bus slave and transmitter: lat = cycles a request waits before its handshake
    always @(negedge clk_in) begin
        if (write_valid) begin
            wk++;
            write_ready = wk == wr_lat + 1;
        end else begin
            wk = 0;
            write_ready = 1'b0;
        end
        if (read_ready) begin
            rk++;
            read_valid = rk == rd_lat + 1;
            read_data = read_valid ? rd_val : $urandom;
        end else begin
            rk = 0;
            read_valid = 1'($urandom_range(0, 1));
            read_data = $urandom;
        end
        tk++;
        tx_data_ready = tx_mode == 0 ? 1'b1 : tx_mode == 1 ? (tk % 4 == 1 || tk % 4 == 0) : 1'($urandom_range(0, 1));
    end

    always @(posedge clk_in) begin
        if (rx_data_valid && rx_data_ready) last_acc = cyc;
        if ((write_valid || read_ready) && !prev_req) begin
            req_start = cyc;
            bus_reqs++;
        end
        prev_req = write_valid || read_ready;
        if (write_valid) begin
            wv_run++;
            if (write_ready) begin
                wa_q.push_back(write_address);
                wd_q.push_back(write_data);
            end
        end else if (wv_run != 0) begin
            wv_len.push_back(wv_run);
            wv_run = 0;
        end
        if (prev_wv && write_valid) begin
            checks++;
            if (write_address !== pa || write_data !== pd) begin
                fails++;
                $display("FAIL wr_stable: got %h/%h want %h/%h", write_address, write_data, pa, pd);
            end
        end
        if (prev_rr && read_ready) begin
            checks++;
            if (read_address !== pra) begin
                fails++;
                $display("FAIL rd_stable: got %h want %h", read_address, pra);
            end
        end
        if (hold_p && tx_data_valid) begin
            checks++;
            if (tx_data !== hold_b) begin
                fails++;
                $display("FAIL tx_hold: got %h want %h", tx_data, hold_b);
            end
        end
        if (read_ready && read_valid) ra_q.push_back(read_address);
        if (tx_data_valid && tx_data_ready) begin
            tx_q.push_back(tx_data);
            tx_t.push_back(cyc);
        end
        prev_wv = write_valid;
        prev_rr = read_ready;
        pa = write_address;
        pd = write_data;
        pra = read_address;
        hold_p = tx_data_valid && !tx_data_ready;
        hold_b = tx_data;
        cyc++;
    end

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        rx_data = b;
        rx_data_valid = 1'b1;
        while (!rx_data_ready && n < 5000) begin
            @(negedge clk_in);
            n++;
        end
        if (n >= 5000) begin
            fails++;
            $display("FAIL rx_accept: got ready 0 want 1 for byte %h", b);
        end
        @(negedge clk_in);
        rx_data_valid = 1'b0;
    endtask

    task automatic model(input logic [7:0] cmd, input int lat, input logic [31:0] rv);
        exp_q = {};
        if (cmd == 8'h57) exp_q.push_back(lat < TMO ? 8'h06 : 8'h15);
        else if (cmd == 8'h52 && lat < TMO) for (int i = 3; i >= 0; i--) exp_q.push_back(8'(rv >> (8 * i)));
        else exp_q.push_back(8'h15);
    endtask

    task automatic run_frame(input string nm, input logic [7:0] cmd, input logic [31:0] a, input logic [31:0] d,
                             input int lat, input logic [31:0] rv);
        int n = 0;
        int r0;
        logic legal;
        legal = cmd == 8'h57 || cmd == 8'h52;
        wr_lat = lat;
        rd_lat = lat;
        rd_val = rv;
        tx_q = {};
        tx_t = {};
        wa_q = {};
        wd_q = {};
        wv_len = {};
        ra_q = {};
        r0 = bus_reqs;
        model(cmd, lat, rv);
        @(negedge clk_in);
        send_byte(cmd);
        if (legal) for (int i = 3; i >= 0; i--) send_byte(8'(a >> (8 * i)));
        if (cmd == 8'h57) for (int i = 3; i >= 0; i--) send_byte(8'(d >> (8 * i)));
        while (tx_q.size() < exp_q.size() && n < TMO + 500) begin
            @(negedge clk_in);
            n++;
        end
        repeat (3) @(negedge clk_in);
        checks++;
        if (tx_q.size() != exp_q.size()) begin
            fails++;
            $display("FAIL %s resp_count: got %0d want %0d", nm, tx_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < tx_q.size(); i++) begin
            checks++;
            if (tx_q[i] !== exp_q[i]) begin
                fails++;
                $display("FAIL %s resp_byte%0d: got %h want %h", nm, i, tx_q[i], exp_q[i]);
            end
        end
        checks++;
        if (bus_reqs - r0 != (legal ? 1 : 0)) begin
            fails++;
            $display("FAIL %s bus_requests: got %0d want %0d", nm, bus_reqs - r0, legal ? 1 : 0);
        end
        if (legal) begin
            checks++;
            if (req_start != last_acc + 1) begin
                fails++;
                $display("FAIL %s req_latency: got %0d want %0d", nm, req_start - last_acc, 1);
            end
        end
        if (cmd == 8'h57) begin
            checks++;
            if (wa_q.size() != (lat < TMO ? 1 : 0)) begin
                fails++;
                $display("FAIL %s write_count: got %0d want %0d", nm, wa_q.size(), lat < TMO ? 1 : 0);
            end else if (wa_q.size() == 1) begin
                checks++;
                if (wa_q[0] !== a || wd_q[0] !== d) begin
                    fails++;
                    $display("FAIL %s write_addr_data: got %h/%h want %h/%h", nm, wa_q[0], wd_q[0], a, d);
                end
            end
            checks++;
            if (wv_len.size() != 1 || wv_len[0] != (lat < TMO ? lat + 1 : TMO)) begin
                fails++;
                $display("FAIL %s write_valid_cycles: got %0d want %0d", nm, wv_len.size() == 1 ? wv_len[0] : -1,
                         lat < TMO ? lat + 1 : TMO);
            end
        end
        if (cmd == 8'h52 && lat < TMO) begin
            checks++;
            if (ra_q.size() != 1 || ra_q[0] !== a) begin
                fails++;
                $display("FAIL %s read_addr: got %h want %h", nm, ra_q.size() == 1 ? ra_q[0] : 32'hx, a);
            end
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk_in);
        checks++;
        if ({write_valid, read_ready, tx_data_valid, tx_data} !== 11'h0) begin
            fails++;
            $display("FAIL reset_ctrl: got %h want %h", {write_valid, read_ready, tx_data_valid, tx_data}, 11'h0);
        end
        checks++;
        if ({write_address, write_data, read_address} !== 96'h0) begin
            fails++;
            $display("FAIL reset_bus: got %h want 0", {write_address, write_data, read_address});
        end
        checks++;
        if (rx_data_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_rx_ready: got %b want 1", rx_data_ready);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_write;
        run_frame("write", 8'h57, 32'h0000_1004, 32'hDEAD_BEEF, 0, 32'h0);
    endtask

    task automatic test_read;
        tx_mode = 0;
        run_frame("read", 8'h52, 32'h0000_1008, 32'h0, 5, 32'h1234_5678);
        checks++;
        if (tx_t.size() != 4 || tx_t[3] - tx_t[0] != 3) begin
            fails++;
            $display("FAIL read_no_bubble: got span %0d want 3", tx_t.size() == 4 ? tx_t[3] - tx_t[0] : -1);
        end
    endtask

    task automatic test_illegal;
        run_frame("illegal", 8'h41, 32'h0, 32'h0, 0, 32'h0);
        run_frame("after_illegal", 8'h57, 32'hA5A5_0001, 32'h0102_0304, 2, 32'h0);
    endtask

    task automatic test_timeout;
        run_frame("wr_timeout", 8'h57, 32'h0000_2000, 32'h5555_AAAA, TMO, 32'h0);
        run_frame("wr_last_cycle", 8'h57, 32'h0000_2004, 32'h0F0F_F0F0, TMO - 1, 32'h0);
        run_frame("rd_timeout", 8'h52, 32'h0000_2008, 32'h0, TMO, 32'hCAFE_F00D);
    endtask

    task automatic test_backpressure;
        tx_mode = 1;
        run_frame("tx_backpressure", 8'h52, 32'h0000_3000, 32'h0, 1, 32'h89AB_CDEF);
        tx_mode = 0;
    endtask

    task automatic test_reset_mid;
        int r0;
        r0 = bus_reqs;
        @(negedge clk_in);
        send_byte(8'h57);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        rst_n = 1'b0;
        tx_q = {};
        #1;
        checks++;
        if ({write_valid, tx_data_valid, rx_data_ready, write_address} !== {3'b001, 32'h0}) begin
            fails++;
            $display("FAIL midreset_outputs: got %h want %h", {write_valid, tx_data_valid, rx_data_ready, write_address},
                     {3'b001, 32'h0});
        end
        repeat (2) @(negedge clk_in);
        rst_n = 1'b1;
        repeat (20) @(negedge clk_in);
        checks++;
        if (tx_q.size() != 0 || bus_reqs != r0) begin
            fails++;
            $display("FAIL midreset_silence: got %0d bytes/%0d reqs want 0/0", tx_q.size(), bus_reqs - r0);
        end
        run_frame("after_reset", 8'h57, 32'h1122_3344, 32'h5566_7788, 1, 32'h0);
    endtask

    task automatic test_random;
        logic [7:0] c;
        tx_mode = 2;
        for (int i = 0; i < 20; i++) begin
            case ($urandom_range(0, 2))
                0: c = 8'h57;
                1: c = 8'h52;
                default: begin
                    c = 8'($urandom);
                    while (c == 8'h57 || c == 8'h52) c = 8'($urandom);
                end
            endcase
            run_frame("random", c, $urandom, $urandom, $urandom_range(0, 8), $urandom);
        end
        tx_mode = 0;
    endtask

    initial begin
        #2_000_000;
        fails++;
        $display("FAIL watchdog: got timeout want completion");
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_write();
        test_read();
        test_illegal();
        test_timeout();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
